// File: rtl/debounce_filter.sv
// Debounce filter: two-flop synchroniser followed by a stability-qualified level FSM.
// Produces a clean level Z, one-cycle rise/fall pulses and a saturating glitch count.
module debounce_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                A,
    output logic                Z,
    output logic                rise,
    output logic                fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    // state      | meaning
    // ST_LOW     | Z=0 accepted, waiting for s2 to go high
    // CHK_HIGH   | s2 high, counting consecutive high samples
    // ST_HIGH    | Z=1 accepted, waiting for s2 to go low
    // CHK_LOW    | s2 low, counting consecutive low samples
    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        CHK_HIGH = 2'd1,
        ST_HIGH  = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic                s1_q, s2_q;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                z_q, z_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic [GLITCH_W-1:0] glitch_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            z_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            s1_q     <= A;
            s2_q     <= s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // Saturate at all-ones so a noisy line never wraps back to a small count.
    assign glitch_inc = (&glitch_q) ? glitch_q : glitch_q + GLITCH_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;
        case (state_q)
            ST_LOW: begin
                if (s2_q) begin
                    state_d = CHK_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!s2_q) begin
                    state_d  = ST_LOW;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    z_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s2_q) begin
                    state_d = CHK_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LOW: begin
                if (s2_q) begin
                    state_d  = ST_HIGH;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    z_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign Z          = z_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = (state_q == CHK_HIGH) || (state_q == CHK_LOW);
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: directed latency/glitch scenarios plus random bounce
// traffic, all compared against a run-length model of the qualification rule.
module tb_debounce_filter;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_in = 1'b0;

    logic       z_b, rise_b, fall_b, busy_b;
    logic [7:0] gc_b;
    logic       z_s, rise_s, fall_s, busy_s;
    logic [1:0] gc_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: delay line for the synchroniser and a count of how many
    // consecutive evaluations the synchronised input has disagreed with Z.
    bit m_s1, m_s2, m_z, m_rise, m_fall, m_valid;
    int pend;
    int g_big, g_small;

    always #5 clk = ~clk;

    debounce_filter #(.STABLE_CYCLES(STABLE), .CNT_W(8), .GLITCH_W(8)) u_dut_big (
        .clk(clk), .rst(rst), .A(a_in),
        .Z(z_b), .rise(rise_b), .fall(fall_b), .busy(busy_b), .glitch_cnt(gc_b)
    );

    debounce_filter #(.STABLE_CYCLES(STABLE), .CNT_W(8), .GLITCH_W(2)) u_dut_small (
        .clk(clk), .rst(rst), .A(a_in),
        .Z(z_s), .rise(rise_s), .fall(fall_s), .busy(busy_s), .glitch_cnt(gc_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit a, input bit r);
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_z = 0; m_rise = 0; m_fall = 0;
            pend = 0; g_big = 0; g_small = 0; m_valid = 1;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (m_s2 != m_z) begin
                pend++;
                if (pend == STABLE) begin
                    m_z = m_s2;
                    if (m_z) m_rise = 1; else m_fall = 1;
                    pend = 0;
                end
            end else begin
                if (pend > 0) begin
                    g_big   = (g_big < 255) ? g_big + 1 : 255;
                    g_small = (g_small < 3) ? g_small + 1 : 3;
                end
                pend = 0;
            end
            m_s2 = m_s1;
            m_s1 = a;
        end
    endtask

    task automatic step(input bit a, input bit r);
        a_in = a;
        rst  = r;
        @(posedge clk);
        model_edge(a, r);
        #1;
        if (m_valid) begin
            check_eq("z",        z_b,    m_z);
            check_eq("rise",     rise_b, m_rise);
            check_eq("fall",     fall_b, m_fall);
            check_eq("busy",     busy_b, pend > 0);
            check_eq("glitch",   gc_b,   g_big);
            check_eq("z_s",      z_s,    m_z);
            check_eq("busy_s",   busy_s, pend > 0);
            check_eq("glitch_s", gc_s,   g_small);
            check_eq("rise_fall_excl", rise_b & fall_b, 0);
        end
    endtask

    // Hold A at 'level' and return the edge index (1-based) at which Z reaches it.
    task automatic measure(input bit level, input int first, output int lat);
        lat = 0;
        for (int i = first; i <= 16; i++) begin
            step(level, 0);
            if (lat == 0 && z_b == level) lat = i;
        end
    endtask

    initial begin
        int lat;
        int run;
        bit lvl;
        m_valid = 0;

        // Reset with A high, then full latency after release.
        step(1, 1);
        step(1, 1);
        check_eq("rst_z", z_b, 0);
        check_eq("rst_busy", busy_b, 0);
        check_eq("rst_glitch", gc_b, 0);
        check_eq("rst_rise", rise_b, 0);
        measure(1, 1, lat);
        check_eq("lat_rise_after_rst", lat, 6);

        // Clean release.
        measure(0, 1, lat);
        check_eq("lat_fall", lat, 6);

        // Clean press with explicit busy window.
        step(0, 1);
        for (int i = 1; i <= 6; i++) begin
            step(1, 0);
            if (i >= 3 && i <= 5) check_eq("press_busy", busy_b, 1);
            if (i == 6) begin
                check_eq("press_z", z_b, 1);
                check_eq("press_rise", rise_b, 1);
            end
        end
        step(1, 0);
        check_eq("press_rise_one_cycle", rise_b, 0);

        // Reset while stable high: Z drops, no fall pulse.
        step(1, 1);
        check_eq("rst_high_z", z_b, 0);
        check_eq("rst_high_fall", fall_b, 0);

        // Short glitch.
        step(0, 1);
        step(1, 0);
        step(1, 0);
        for (int i = 0; i < 6; i++) step(0, 0);
        check_eq("short_glitch_z", z_b, 0);
        check_eq("short_glitch_cnt", gc_b, 1);

        // Bounce train then held high; latency counted from the final rise.
        step(0, 1);
        for (int i = 0; i < 10; i++) begin
            step(i[0], 0);
            check_eq("bounce_z", z_b, 0);
        end
        measure(1, 2, lat);
        check_eq("bounce_lat", lat, 6);
        check_eq("bounce_glitch_nz", gc_b != 0, 1);

        // Saturation on the narrow counter.
        step(0, 1);
        for (int g = 0; g < 5; g++) begin
            step(1, 0);
            step(1, 0);
            for (int i = 0; i < 4; i++) step(0, 0);
        end
        check_eq("sat_small", gc_s, 3);
        check_eq("sat_big", gc_b, 5);

        // Reset mid-CHECK_HIGH, then requalify with full latency.
        for (int i = 0; i < 4; i++) step(1, 0);
        check_eq("midchk_busy", busy_b, 1);
        step(1, 1);
        check_eq("midchk_rst_busy", busy_b, 0);
        check_eq("midchk_rst_z", z_b, 0);
        check_eq("midchk_rst_gs", gc_s, 0);
        measure(1, 1, lat);
        check_eq("midchk_lat", lat, 6);

        // Random bounce traffic with occasional resets.
        lvl = 0;
        for (int c = 0; c < 3000; ) begin
            run = $urandom_range(1, 7);
            lvl = ~lvl;
            for (int k = 0; k < run; k++) begin
                step(lvl, $urandom_range(0, 299) == 0);
                c++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
